// File: rtl/mcu_io_pkg.sv
// Shared definitions for the MCU-to-GPIO register bridge: register map regions,
// handshake FSM states and sizing helpers.
package mcu_io_pkg;

    localparam logic [1:0] REG_DATA = 2'b00;
    localparam logic [1:0] REG_DIR  = 2'b01;
    localparam logic [1:0] REG_CHG  = 2'b10;
    localparam logic [1:0] REG_RSVD = 2'b11;

    // Edge detection stays off this many cycles after reset while synchronisers fill
    localparam int SYNC_SETTLE = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    function automatic int num_banks(input int pin_count, input int data_w);
        return (pin_count + data_w - 1) / data_w;
    endfunction

endpackage

// File: rtl/pin_sync.sv
// Two-flop synchroniser for asynchronous inputs; both stages clear to 0 in reset.
module pin_sync #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/mcu_io_bridge.sv
// MCU strobe/ack register bridge onto a bank of GPIO pins with direction control,
// synchronised readback, per-pin change flags and a level interrupt.
module mcu_io_bridge
    import mcu_io_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PIN_COUNT = 132,
    parameter int ADDR_W    = 7
) (
    input  logic                 CLK50,
    input  logic                 RST_N,
    input  logic [ADDR_W-1:0]    address,
    input  logic [DATA_W-1:0]    data_in,
    output logic [DATA_W-1:0]    data_out,
    output logic                 data_oe,
    input  logic                 mcu_mstr,
    input  logic                 write_enable,
    output logic                 fpga_ready,
    output logic                 fpga_ack,
    input  logic [PIN_COUNT-1:0] pin_in,
    output logic [PIN_COUNT-1:0] pin_out,
    output logic [PIN_COUNT-1:0] pin_oe,
    output logic                 irq
);

    localparam int NUM_BANKS = num_banks(PIN_COUNT, DATA_W);
    localparam int BANK_W    = ADDR_W - 2;
    localparam int SETTLE_W  = $clog2(SYNC_SETTLE + 1);

    logic [1:0]           w_ctl_s;
    logic                 w_mstr_s;
    logic                 w_we_s;
    logic [PIN_COUNT-1:0] w_in_sync;

    pin_sync #(.WIDTH(2)) u_ctl_sync (
        .i_clk   (CLK50),
        .i_rst_n (RST_N),
        .i_d     ({write_enable, mcu_mstr}),
        .o_q     (w_ctl_s)
    );

    pin_sync #(.WIDTH(PIN_COUNT)) u_pin_sync (
        .i_clk   (CLK50),
        .i_rst_n (RST_N),
        .i_d     (pin_in),
        .o_q     (w_in_sync)
    );

    assign w_mstr_s = w_ctl_s[0];
    assign w_we_s   = w_ctl_s[1];

    state_t                r_state;
    state_t                w_next;
    logic [PIN_COUNT-1:0]  r_pin_out;
    logic [PIN_COUNT-1:0]  r_pin_oe;
    logic [PIN_COUNT-1:0]  r_chg;
    logic [PIN_COUNT-1:0]  r_in_prev;
    logic                  r_irq;
    logic [DATA_W-1:0]     r_data_out;
    logic                  r_data_oe;
    logic                  r_ack;
    logic                  r_ready;
    logic [SETTLE_W-1:0]   r_settle;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_mstr_s) w_next = ST_ACCESS;
            ST_ACCESS: w_next = ST_ACK;
            ST_ACK:    if (!w_mstr_s) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Address and data are sampled raw in ACCESS: the MCU holds them while strobing.
    logic [1:0]           w_region;
    logic [BANK_W-1:0]    w_bank;
    logic                 w_bank_ok;
    logic [31:0]          w_lsb;
    logic [PIN_COUNT-1:0] w_mask;
    logic [PIN_COUNT-1:0] w_wdata;
    logic                 w_access;
    logic                 w_wr;
    logic                 w_rd;
    logic [PIN_COUNT-1:0] w_view;
    logic [DATA_W-1:0]    w_rdata;
    logic [PIN_COUNT-1:0] w_edge;
    logic [PIN_COUNT-1:0] w_clr;
    logic                 w_settled;

    assign w_region  = address[ADDR_W-1 -: 2];
    assign w_bank    = address[BANK_W-1:0];
    assign w_bank_ok = 32'(w_bank) < 32'(NUM_BANKS);
    assign w_lsb     = 32'(w_bank) * 32'(DATA_W);
    assign w_mask    = w_bank_ok ? (PIN_COUNT'({DATA_W{1'b1}}) << w_lsb) : '0;
    assign w_wdata   = PIN_COUNT'(data_in) << w_lsb;
    assign w_access  = (r_state == ST_ACCESS);
    assign w_wr      = w_access && w_we_s;
    assign w_rd      = w_access && !w_we_s;

    always_comb begin
        w_view = '0;
        case (w_region)
            REG_DATA: w_view = (r_pin_oe & r_pin_out) | (~r_pin_oe & w_in_sync);
            REG_DIR:  w_view = r_pin_oe;
            REG_CHG:  w_view = r_chg;
            default:  w_view = '0;
        endcase
    end

    // Shifting the pin-wide view down zero-fills bits past the last pin.
    assign w_rdata   = w_bank_ok ? DATA_W'(w_view >> w_lsb) : '0;

    assign w_settled = (r_settle == SETTLE_W'(SYNC_SETTLE));
    assign w_edge    = (w_in_sync ^ r_in_prev) & ~r_pin_oe & {PIN_COUNT{w_settled}};
    assign w_clr     = (w_wr && w_region == REG_CHG) ? (w_mask & w_wdata) : '0;

    always_ff @(posedge CLK50) begin
        if (!RST_N) begin
            r_state    <= ST_IDLE;
            r_pin_out  <= '0;
            r_pin_oe   <= '0;
            r_chg      <= '0;
            r_in_prev  <= '0;
            r_irq      <= 1'b0;
            r_data_out <= '0;
            r_data_oe  <= 1'b0;
            r_ack      <= 1'b0;
            r_ready    <= 1'b0;
            r_settle   <= '0;
        end else begin
            r_state   <= w_next;
            r_ready   <= (w_next == ST_IDLE);
            r_ack     <= (w_next == ST_ACK);
            r_data_oe <= (w_next == ST_ACK) && (w_access ? !w_we_s : r_data_oe);

            if (w_wr && w_region == REG_DATA)
                r_pin_out <= (r_pin_out & ~w_mask) | (w_wdata & w_mask);
            if (w_wr && w_region == REG_DIR)
                r_pin_oe <= (r_pin_oe & ~w_mask) | (w_wdata & w_mask);
            if (w_rd)
                r_data_out <= w_rdata;

            // A new edge overrides a simultaneous write-1-to-clear of the same bit.
            r_chg     <= (r_chg & ~w_clr) | w_edge;
            r_irq     <= |r_chg;
            r_in_prev <= w_in_sync;
            if (!w_settled)
                r_settle <= r_settle + SETTLE_W'(1);
        end
    end

    assign data_out   = r_data_out;
    assign data_oe    = r_data_oe;
    assign fpga_ack   = r_ack;
    assign fpga_ready = r_ready;
    assign pin_out    = r_pin_out;
    assign pin_oe     = r_pin_oe;
    assign irq        = r_irq;

endmodule
